dma_io_device: RTL and testbench
================================

Name: dma_io_device

Overview:
- Synthesizable DMA-side I/O peripheral that sits at the other end of the 8237A DREQ/DACK handshake from the DMA controller.
- Raises DREQ on behalf of a local data port and waits for DACK.
- During DACK it sources data on DB on IOR_N strobes (Mode 0, device-to-memory) or sinks data from DB on IOW_N strobes (Mode 1, memory-to-device), buffering through an internal FIFO.
- Honours EOP_N (terminal count). It is used in the controller's system-level bench and as the reference DMA client in the chip.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- WIDTH, 8, data width; matches DB.

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- Enable  in  1  channel enable; low clears the Terminated/Underrun/Overrun flags
- Mode  in  1  0 = device-to-memory (IOR_N), 1 = memory-to-device (IOW_N); latched only in IDLE
- DREQ  out  1  DMA request to controller, active-high
- DACK  in  1  DMA acknowledge, active-high
- IOR_N  in  1  I/O read strobe, active-low
- IOW_N  in  1  I/O write strobe, active-low
- EOP_N  in  1  end of process / terminal count, active-low
- DB  inout  WIDTH  system data bus
- RxData  in  WIDTH  local data into FIFO (Mode 0)
- RxValid  in  1  RxData valid
- RxReady  out  1  FIFO accepts RxData
- TxData  out  WIDTH  FIFO head to local sink (Mode 1)
- TxValid  out  1  TxData valid
- TxReady  in  1  local sink accepts TxData
- Level  out  log2(DEPTH)+1  FIFO occupancy
- Done  out  1  one-cycle pulse on terminal count
- Underrun  out  1  sticky: IOR strobe with FIFO empty
- Overrun  out  1  sticky: IOW strobe with FIFO full

Behaviour:
- Reset (async, Reset=0): state IDLE, ModeReg=0, FIFO empty, Level=0, DREQ=0, Done=0, Underrun=0, Overrun=0, TxValid=0, RxReady=0, DB=Z.
- Demand condition: Mode 0 → Level!=0; Mode 1 → Level!=DEPTH.
- Strobe edge detection: IOR_N and IOW_N are registered each cycle; a strobe completes on the cycle the registered value is 0 and the input is 1.
- While IOW_N=0, DB is captured into a holding register every cycle.
- State IDLE:
  - DREQ=0; ModeReg<=Mode.
  - Go to REQ if Enable && demand && !Terminated.
- State REQ:
  - DREQ=1.
  - If DACK=1, go to XFER.
  - Else if Enable=0 or the demand condition drops, go to IDLE.
- State XFER:
  - DREQ=1 while demand holds, else 0.
  - Mode 0: DB driven with the FIFO head when DACK && !IOR_N. If the FIFO is empty, DB is driven with all-ones instead.
  - On IOR completion: pop the FIFO; if it was empty, set Underrun and do not pop.
  - Mode 1: on IOW completion, push the holding register; if the FIFO is full, drop the data and set Overrun.
  - EOP_N=0 sampled while DACK=1: the current strobe still completes normally, then go to TERM.
  - DACK=0 (and no EOP): go to IDLE.
- State TERM:
  - DREQ=0, Terminated=1, Done=1 for the entry cycle only.
  - Stay until Enable=0, then go to IDLE.
- DB is Z in every case not listed above; the device never drives DB when DACK=0.
- Local port:
  - RxReady = Enable && ModeReg==0 && !full.
  - TxValid = ModeReg==1 && !empty.
  - TxData = FIFO head.
  - A bus-side pop/push and a local push/pop in the same cycle are both performed; Level updates by the net change, with no lost entry.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - full = (MSBs differ && LSBs equal).
  - empty = pointers equal.
  - The FIFO is not flushed by Enable or by a Mode change.
- Mode changes outside IDLE are ignored until the next return to IDLE.
- Async reset mid-XFER: DB goes to Z and DREQ goes to 0 within the reset assertion, with no clock required.
- Level-to-DREQ latency: 1 clock (IDLE→REQ). DACK-to-data latency: combinational once in XFER.

Test Plan:
- Reset with DACK=1, IOR_N=0 → DREQ=0, DB=Z, Level=0, Done=0. After deasserting Reset, Enable=1, Mode=0, with no Rx data → DREQ stays 0.
- Mode 0: push 8'h11, 8'h22, 8'h33 via Rx; DACK=1; issue three IOR_N low pulses of 2 clocks each → DB shows 11, 22, 33 during each pulse; Level goes 3→0. DREQ drops after the third pulse completes; a fourth pulse → DB=FF, Underrun=1.
- Mode 1, DEPTH=8: DACK=1 and 9 IOW_N pulses with DB=8'h40..8'h48 → TxData order 40..47, Level=8, DREQ=0 after the 8th, Overrun=1 after the 9th, 48 dropped. TxReady=1 → drains 40..47 in 8 clocks.
- Simultaneous: Mode 0, Level=4, RxValid=1 in the same cycle as an IOR completion → Level stays 4 and data order is preserved.
- EOP_N low during the 2nd of 5 IOR pulses → 2 pops total, Done pulses once, DREQ=0 with Level=3 remaining. Enable 1→0→1 → REQ re-entered and DREQ=1.
- Reset asserted mid-XFER while DB is driven → DB=Z and DREQ=0 asynchronously; FIFO empty after release.

Source files
------------

// File: rtl/dma_io_device.sv
`default_nettype none
// ============================================================================
// Module   : dma_io_device
// Purpose  : DMA client peripheral for the 8237A DREQ/DACK handshake.
//            Device-to-memory (mode 0): local Rx data is buffered in a FIFO
//            and sourced onto DB on IOR_N strobes.
//            Memory-to-device (mode 1): DB is sunk on IOW_N strobes into the
//            FIFO and presented on the local Tx port.
//            EOP_N terminates the transfer until the channel is re-enabled.
// Revision : 1.0 - initial release
// ============================================================================
module dma_io_device #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     i_mode,
  output logic                     o_dreq,
  input  logic                     i_dack,
  input  logic                     i_ior_n,
  input  logic                     i_iow_n,
  input  logic                     i_eop_n,
  inout  wire  [WIDTH-1:0]         io_db,
  input  logic [WIDTH-1:0]         i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_rx_ready,
  output logic [WIDTH-1:0]         o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_done,
  output logic                     o_underrun,
  output logic                     o_overrun
);

  localparam int c_aw = $clog2(DEPTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_xfer = 2'd2;
  localparam logic [1:0] c_st_term = 2'd3;

  // Registered state
  logic [1:0]       r_state;
  logic             r_mode;
  logic             r_terminated;
  logic             r_done;
  logic             r_underrun;
  logic             r_overrun;
  logic             r_eop_pend;
  logic             r_ior_q;
  logic             r_iow_q;
  logic [WIDTH-1:0] r_hold;
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Combinational
  logic [1:0]       w_state_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_mode_eff;
  logic             w_demand;
  logic             w_in_xfer;
  logic             w_ior_done;
  logic             w_iow_done;
  logic             w_bus_pop;
  logic             w_bus_push;
  logic             w_underrun_set;
  logic             w_overrun_set;
  logic             w_rx_ready;
  logic             w_tx_valid;
  logic             w_loc_push;
  logic             w_loc_pop;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_push_data;
  logic [WIDTH-1:0] w_head;
  logic             w_strobe_busy;
  logic             w_eop_seen;
  logic             w_db_oe;
  logic [WIDTH-1:0] w_db_out;

  // FIFO status: extra pointer MSB distinguishes full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

  // In IDLE the mode input is about to be latched, so demand tracks it
  // directly; elsewhere the latched mode governs.
  assign w_mode_eff = (r_state == c_st_idle) ? i_mode : r_mode;
  assign w_demand   = w_mode_eff ? !w_full : !w_empty;
  assign w_in_xfer  = (r_state == c_st_xfer);

  // Strobe completion = rising edge of the strobe seen against its last sample
  assign w_ior_done = w_in_xfer && !r_mode && !r_ior_q && i_ior_n;
  assign w_iow_done = w_in_xfer &&  r_mode && !r_iow_q && i_iow_n;

  assign w_bus_pop      = w_ior_done && !w_empty;
  assign w_underrun_set = w_ior_done &&  w_empty;
  assign w_bus_push     = w_iow_done && !w_full;
  assign w_overrun_set  = w_iow_done &&  w_full;

  // Local port: only one direction is live per mode, so each cycle has at
  // most one push and one pop.
  assign w_rx_ready  = i_enable && !r_mode && !w_full;
  assign w_tx_valid  = r_mode && !w_empty;
  assign w_loc_push  = i_rx_valid && w_rx_ready;
  assign w_loc_pop   = w_tx_valid && i_tx_ready;
  assign w_push      = w_bus_push || w_loc_push;
  assign w_pop       = w_bus_pop  || w_loc_pop;
  assign w_push_data = r_mode ? r_hold : i_rx_data;

  // A strobe still held low must finish before terminal count takes effect
  assign w_strobe_busy = r_mode ? !i_iow_n : !i_ior_n;
  assign w_eop_seen    = (i_dack && !i_eop_n) || r_eop_pend;

  // Bus drive depends only on state and live inputs so async reset releases it
  assign w_db_oe  = w_in_xfer && !r_mode && i_dack && !i_ior_n;
  assign w_db_out = w_empty ? {WIDTH{1'b1}} : w_head;
  assign io_db    = w_db_oe ? w_db_out : {WIDTH{1'bz}};

  assign o_rx_ready = w_rx_ready;
  assign o_tx_valid = w_tx_valid;
  assign o_tx_data  = w_head;
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_done     = r_done;
  assign o_underrun = r_underrun;
  assign o_overrun  = r_overrun;

  // Next-state selection for the DREQ/DACK handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (i_enable && w_demand && !r_terminated) w_state_nxt = c_st_req;
      end
      c_st_req: begin
        if (i_dack)                         w_state_nxt = c_st_xfer;
        else if (!i_enable || !w_demand)    w_state_nxt = c_st_idle;
      end
      c_st_xfer: begin
        if (w_eop_seen) begin
          if (!w_strobe_busy)               w_state_nxt = c_st_term;
        end else if (!i_dack) begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_term: begin
        if (!i_enable)                      w_state_nxt = c_st_idle;
      end
      default:                              w_state_nxt = c_st_idle;
    endcase
  end

  // DREQ is asserted in REQ and held in XFER only while more data can move
  always_comb begin
    o_dreq = 1'b0;
    case (r_state)
      c_st_req:  o_dreq = 1'b1;
      c_st_xfer: o_dreq = w_demand;
      default:   o_dreq = 1'b0;
    endcase
  end

  // Sample strobes for edge detection and capture DB while IOW_N is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ior_q <= 1'b1;
      r_iow_q <= 1'b1;
      r_hold  <= '0;
    end else begin
      r_ior_q <= i_ior_n;
      r_iow_q <= i_iow_n;
      if (!i_iow_n) r_hold <= io_db;
    end
  end

  // Handshake state, latched mode, pending EOP and terminal-count pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_mode     <= 1'b0;
      r_eop_pend <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == c_st_idle) r_mode <= i_mode;
      r_eop_pend <= w_in_xfer && (w_state_nxt == c_st_xfer) && w_eop_seen;
      r_done     <= (r_state != c_st_term) && (w_state_nxt == c_st_term);
    end
  end

  // Sticky status flags, all released by dropping the channel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_terminated <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!i_enable) begin
      r_terminated <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_state_nxt == c_st_term) r_terminated <= 1'b1;
      if (w_underrun_set)           r_underrun   <= 1'b1;
      if (w_overrun_set)            r_overrun    <= 1'b1;
    end
  end

  // FIFO pointers; a push and a pop in one cycle both advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are never observed while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= w_push_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_io_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_io_device
// Purpose  : Directed checks of dma_io_device: reset, mode 0 sourcing,
//            mode 1 sinking, simultaneous bus/local traffic, EOP, async reset.
//            An undriven DB is pulled low so a released bus reads 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_io_device;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic       dack;
  logic       ior_n;
  logic       iow_n;
  logic       eop_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] db;
  logic       dreq;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] level;
  logic       done;
  logic       underrun;
  logic       overrun;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign db = tb_drv ? tb_val : 8'hzz;
  pulldown (db);

  always #5 clk = ~clk;

  dma_io_device #(.DEPTH(8), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enable   (enable),
    .i_mode     (mode),
    .o_dreq     (dreq),
    .i_dack     (dack),
    .i_ior_n    (ior_n),
    .i_iow_n    (iow_n),
    .i_eop_n    (eop_n),
    .io_db      (db),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_level    (level),
    .o_done     (done),
    .o_underrun (underrun),
    .o_overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Two-clock IOR_N low pulse; optional EOP in the first clock and an Rx push
  // in the completion clock.
  task automatic ior_pulse(input logic [7:0] exp_db, input bit with_eop,
                           input bit with_rx, input logic [7:0] rx_d, input string tag);
    ior_n = 1'b0;
    if (with_eop) eop_n = 1'b0;
    #1 chk({tag, "_db_a"}, db, exp_db);
    @(negedge clk);
    eop_n = 1'b1;
    #1 chk({tag, "_db_b"}, db, exp_db);
    @(negedge clk);
    ior_n = 1'b1;
    if (with_rx) begin
      rx_valid = 1'b1;
      rx_data  = rx_d;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic iow_pulse(input logic [7:0] d);
    tb_val = d;
    tb_drv = 1'b1;
    iow_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    iow_n  = 1'b1;
    tb_drv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; dack = 1'b1;
    ior_n = 1'b0; iow_n = 1'b1; eop_n = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    tb_drv = 1'b0; tb_val = 8'h00;

    // Reset with DACK and IOR asserted
    #3;
    chk("rst_dreq", dreq, 0);
    chk("rst_db", db, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_rxready", rx_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; dack = 1'b0; ior_n = 1'b1; enable = 1'b1; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_dreq", dreq, 0);
    chk("idle_rxready", rx_ready, 1);

    // Mode 0: source three bytes, then underrun
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    chk("m0_level3", level, 3);
    chk("m0_dreq_req", dreq, 1);
    dack = 1'b1;
    @(negedge clk);
    ior_pulse(8'h11, 0, 0, 8'h00, "m0_p1");
    chk("m0_level2", level, 2);
    chk("m0_dreq_xfer", dreq, 1);
    ior_pulse(8'h22, 0, 0, 8'h00, "m0_p2");
    chk("m0_level1", level, 1);
    ior_pulse(8'h33, 0, 0, 8'h00, "m0_p3");
    chk("m0_level0", level, 0);
    chk("m0_dreq_drop", dreq, 0);
    chk("m0_no_underrun", underrun, 0);
    ior_pulse(8'hFF, 0, 0, 8'h00, "m0_p4");
    chk("m0_underrun", underrun, 1);
    chk("m0_level_still0", level, 0);

    // Mode 1: sink nine bytes into an 8-deep FIFO, then drain locally
    dack = 1'b0; mode = 1'b1;
    repeat (2) @(negedge clk);
    chk("m1_dreq_req", dreq, 1);
    chk("m1_rxready", rx_ready, 0);
    dack = 1'b1;
    @(negedge clk);
    iow_pulse(8'h40);
    chk("m1_level1", level, 1);
    for (int i = 1; i < 8; i++) iow_pulse(8'h40 + 8'(i));
    chk("m1_level8", level, 8);
    chk("m1_dreq_full", dreq, 0);
    chk("m1_txvalid", tx_valid, 1);
    chk("m1_no_overrun", overrun, 0);
    iow_pulse(8'h48);
    chk("m1_overrun", overrun, 1);
    chk("m1_level_still8", level, 8);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("m1_tx%0d", i), tx_data, 8'h40 + 8'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("m1_drained", level, 0);
    chk("m1_txvalid_off", tx_valid, 0);

    // Simultaneous IOR pop and Rx push at level 4
    dack = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);
    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3); rx_push(8'hA4);
    chk("sim_level4", level, 4);
    dack = 1'b1;
    @(negedge clk);
    ior_pulse(8'hA1, 0, 1, 8'hA5, "sim_p1");
    chk("sim_level_kept", level, 4);
    ior_pulse(8'hA2, 0, 0, 8'h00, "sim_p2");
    ior_pulse(8'hA3, 0, 0, 8'h00, "sim_p3");
    ior_pulse(8'hA4, 0, 0, 8'h00, "sim_p4");
    ior_pulse(8'hA5, 0, 0, 8'h00, "sim_p5");
    chk("sim_level0", level, 0);

    // EOP during the second of five reads
    dack = 1'b0;
    @(negedge clk);
    rx_push(8'hB1); rx_push(8'hB2); rx_push(8'hB3); rx_push(8'hB4); rx_push(8'hB5);
    chk("eop_level5", level, 5);
    dack = 1'b1;
    @(negedge clk);
    ior_pulse(8'hB1, 0, 0, 8'h00, "eop_p1");
    chk("eop_done_early", done, 0);
    ior_pulse(8'hB2, 1, 0, 8'h00, "eop_p2");
    chk("eop_done", done, 1);
    chk("eop_dreq", dreq, 0);
    chk("eop_level3", level, 3);
    @(negedge clk);
    chk("eop_done_once", done, 0);
    ior_pulse(8'h00, 0, 0, 8'h00, "eop_term");
    chk("eop_level_held", level, 3);
    chk("eop_dreq_term", dreq, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("eop_dis_dreq", dreq, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("eop_rereq", dreq, 1);
    chk("eop_flags_clr", underrun, 0);

    // Async reset while DB is driven
    @(negedge clk);
    ior_n = 1'b0;
    #1 chk("ar_db_driven", db, 8'hB3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_db_z", db, 8'h00);
    chk("ar_dreq", dreq, 0);
    @(negedge clk);
    rst_n = 1'b1; ior_n = 1'b1; dack = 1'b0;
    @(negedge clk);
    chk("ar_level0", level, 0);
    chk("ar_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
